imem_encoder: RTL and testbench
===============================

# imem_encoder

Program loader that assembles RV32I instruction words from mnemonic-level descriptors and writes them into instruction memory. It is the encoding counterpart of the control decoder: every instruction the decoder recognises (R-type ALU, I-type ALU/shift, lw, sw, beq, lui, jal) can be produced here. It sits between the testbench or host link and the imem write port, and holds the CPU while a program is loaded.

## Interface
- ADDR_WIDTH, 8: imem word-address width.
- BASE_ADDR, 0: first word address written per session.
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  pulse; opens a load session (honoured only in IDLE).
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid & in_ready.
- in_mnem  in  5  mnemonic code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 addi, 11 andi, 12 ori, 13 xori, 14 slti, 15 sltiu, 16 slli, 17 srli, 18 srai, 19 lw, 20 sw, 21 beq, 22 lui, 23 jal; 24-31 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register fields (ignored where unused).
- in_imm  in  32  signed immediate / byte offset; lui uses in_imm[19:0] as upper 20 bits.
- in_last  in  1  marks final descriptor of session.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_WIDTH  word address.
- imem_wdata  out  32  encoded instruction.
- cpu_hold  out  1  high while session active; CPU must not fetch.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky error, cleared by start.
- err_addr  out  ADDR_WIDTH  address of first errored word.
- count  out  ADDR_WIDTH+1  words written this session.

## Operation
- FSM states IDLE, LOAD, FLUSH.
- IDLE: in_ready=0, cpu_hold=0. start -> LOAD; write pointer <= BASE_ADDR, count <= 0, err <= 0.
- LOAD: in_ready=1, cpu_hold=1. Each handshake encodes the descriptor into a registered word; write pointer increments. Accept with in_last -> FLUSH.
- FLUSH: pending write issues; done pulses; -> IDLE.
- Encoding: R: funct7|rs2|rs1|f3|rd|0110011 (funct7 0100000 for sub, sra). I-ALU: imm[11:0]|rs1|f3|rd|0010011. Shifts: funct7|imm[4:0]|rs1|f3|rd|0010011. lw: f3 010, op 0000011. sw: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011. beq: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011, imm[0] ignored. lui: imm[19:0]|rd|0110111. jal: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111, imm[0] ignored.
- Illegal mnemonic: word written as NOP 0x00000013; err set; err_addr latched if first error.
- Overflow: accept at pointer 2^ADDR_WIDTH-1 without in_last -> word written, err set, err_addr latched, FSM -> FLUSH (session ends, done pulses); pointer never wraps.
- start outside IDLE ignored. Reset mid-session: abort, imem contents not cleared.
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 0, done 0, err 0, err_addr 0, count 0, state IDLE.

## Timing
- start sampled cycle N -> in_ready high cycle N+1.
- Handshake cycle N -> imem_we/addr/wdata valid cycle N+1; count increments cycle N+1.
- Throughput one descriptor per cycle; no back-pressure inside LOAD.
- in_last handshake cycle N -> last write N+1, done pulse N+1, cpu_hold low N+2.
- cpu_hold stays high through the final write cycle.

## Configuration
- IMEM_ENC_IMM_CHECK_EN defined: immediates out of field range (I/S signed 12-bit, shifts 0-31, beq signed 13-bit even, jal signed 21-bit even, lui 20-bit unsigned) set err/err_addr; word still written truncated.
- Undefined: immediates truncated silently; err only for illegal mnemonic/overflow.

## Test plan
- start, then add x3,x1,x2 (last) -> imem_wdata 0x002081B3 at addr 0, done one cycle, count 1.
- addi x5,x0,-1; lui x1,0x12345; sw x2,8(x1) -> 0xFFF00293, 0x123450B7, 0x0020A423 at addr 0,1,2 in consecutive cycles.
- beq x1,x2,-4; jal x1,8 -> 0xFE208EE3, 0x008000EF.
- in_mnem 27 at addr 1 -> 0x00000013 written, err=1, err_addr=1; next start clears err.
- ADDR_WIDTH=2: five descriptors without in_last -> four writes (addr 0-3), err=1, err_addr=3, done pulse, fifth not accepted.
- With IMEM_ENC_IMM_CHECK_EN: addi imm 2048 -> err=1; without macro -> err=0, word 0x80000013 (rd=rs1=0). Reset asserted mid-session -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/imem_encoder_if.sv
// imem_encoder_if: descriptor channel from the host/testbench into the
// program loader. The host drives a descriptor with in_valid; the loader
// accepts it on a cycle where in_ready is also high.
interface imem_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_mnem;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/imem_encoder.sv
// imem_encoder: RV32I program loader. Turns mnemonic-level descriptors into
// instruction words and writes them to imem, one word per accepted
// descriptor, while holding the CPU off the fetch path.
// Optional macro IMEM_ENC_IMM_CHECK_EN: flag immediates that do not fit
// their instruction field (the truncated word is still written).
module imem_encoder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  imem_encoder_if.slave         in_if,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [6:0]            OP_R     = 7'b0110011;
  localparam logic [6:0]            OP_I     = 7'b0010011;
  localparam logic [6:0]            OP_LOAD  = 7'b0000011;
  localparam logic [6:0]            OP_STORE = 7'b0100011;
  localparam logic [6:0]            OP_BR    = 7'b1100011;
  localparam logic [6:0]            OP_LUI   = 7'b0110111;
  localparam logic [6:0]            OP_JAL   = 7'b1101111;
  localparam logic [31:0]           NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        imm_bad;
  logic        accept, at_top, overflow;

  assign rd  = in_if.in_rd;
  assign rs1 = in_if.in_rs1;
  assign rs2 = in_if.in_rs2;
  assign imm = in_if.in_imm;

  // Combinational encoder: descriptor fields -> RV32I word (NOP if illegal)
  always_comb begin
    enc_word    = NOP;
    enc_illegal = 1'b0;
    case (in_if.in_mnem)
      5'd0:  enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OP_R};
      5'd1:  enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, OP_R};
      5'd2:  enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, OP_R};
      5'd3:  enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, OP_R};
      5'd4:  enc_word = {7'b0000000, rs2, rs1, 3'b100, rd, OP_R};
      5'd5:  enc_word = {7'b0000000, rs2, rs1, 3'b001, rd, OP_R};
      5'd6:  enc_word = {7'b0000000, rs2, rs1, 3'b101, rd, OP_R};
      5'd7:  enc_word = {7'b0100000, rs2, rs1, 3'b101, rd, OP_R};
      5'd8:  enc_word = {7'b0000000, rs2, rs1, 3'b010, rd, OP_R};
      5'd9:  enc_word = {7'b0000000, rs2, rs1, 3'b011, rd, OP_R};
      5'd10: enc_word = {imm[11:0], rs1, 3'b000, rd, OP_I};
      5'd11: enc_word = {imm[11:0], rs1, 3'b111, rd, OP_I};
      5'd12: enc_word = {imm[11:0], rs1, 3'b110, rd, OP_I};
      5'd13: enc_word = {imm[11:0], rs1, 3'b100, rd, OP_I};
      5'd14: enc_word = {imm[11:0], rs1, 3'b010, rd, OP_I};
      5'd15: enc_word = {imm[11:0], rs1, 3'b011, rd, OP_I};
      5'd16: enc_word = {7'b0000000, imm[4:0], rs1, 3'b001, rd, OP_I};
      5'd17: enc_word = {7'b0000000, imm[4:0], rs1, 3'b101, rd, OP_I};
      5'd18: enc_word = {7'b0100000, imm[4:0], rs1, 3'b101, rd, OP_I};
      5'd19: enc_word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
      5'd20: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
      5'd21: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BR};
      5'd22: enc_word = {imm[19:0], rd, OP_LUI};
      5'd23: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default: enc_illegal = 1'b1;
    endcase
  end

`ifdef IMEM_ENC_IMM_CHECK_EN
  // Field-range check on the immediate for the selected instruction format
  always_comb begin
    imm_bad = 1'b0;
    case (in_if.in_mnem)
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd19, 5'd20:
        imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
      5'd16, 5'd17, 5'd18:
        imm_bad = |imm[31:5];
      5'd21:
        imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      5'd22:
        imm_bad = |imm[31:20];
      5'd23:
        imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default: imm_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm_hi;
  assign imm_bad       = 1'b0;
  assign unused_imm_hi = ^imm[31:21];
`endif

  // Session sequencing: next state and next values of all registered outputs
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
    accept       = in_ready_q && in_if.in_valid;
    at_top       = (ptr_q == '1);
    overflow     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = BASE;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          overflow     = at_top && !in_if.in_last;
          imem_we_d    = 1'b1;
          imem_addr_d  = ptr_q;
          imem_wdata_d = enc_word;
          count_d      = count_q + (ADDR_WIDTH+1)'(1);
          if (enc_illegal || imm_bad || overflow) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = ptr_q;
          end
          // Pointer saturates at the top word; overflow ends the session.
          if (!at_top) ptr_d = ptr_q + ADDR_WIDTH'(1);
          if (in_if.in_last || overflow) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_LOAD);
    cpu_hold_d = (state_d != S_IDLE);
    done_d     = (state_q == S_LOAD) && (state_d == S_FLUSH);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
      count_q      <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign imem_we        = imem_we_q;
  assign imem_addr      = imem_addr_q;
  assign imem_wdata     = imem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_addr       = err_addr_q;
  assign count          = count_q;

endmodule

// File: tb/tb_imem_encoder.sv
// tb_imem_encoder: scoreboard bench for imem_encoder. Two instances: an
// 8-bit address loader for encoding/session behaviour and a 2-bit address
// loader for pointer overflow.
`timescale 1ns/1ps
module tb_imem_encoder;

`ifdef IMEM_ENC_IMM_CHECK_EN
  localparam bit IMM_CHK = 1'b1;
`else
  localparam bit IMM_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start8 = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  imem_encoder_if if8 ();
  imem_encoder_if if2 ();

  logic        we8, hold8, done8, err8;
  logic [7:0]  addr8, eaddr8;
  logic [8:0]  count8;
  logic [31:0] wdata8;
  logic        we2, hold2, done2, err2;
  logic [1:0]  addr2, eaddr2;
  logic [2:0]  count2;
  logic [31:0] wdata2;

  imem_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .in_if(if8),
    .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8), .cpu_hold(hold8),
    .done(done8), .err(err8), .err_addr(eaddr8), .count(count8)
  );

  imem_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .in_if(if2),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2), .cpu_hold(hold2),
    .done(done2), .err(err2), .err_addr(eaddr2), .count(count2)
  );

  typedef struct { int unsigned addr; logic [31:0] word; } wr_t;
  typedef struct { int unsigned cnt; bit err; int unsigned eaddr; } end_t;

  wr_t  q_wr0[$];
  wr_t  q_wr1[$];
  end_t q_end0[$];
  end_t q_end1[$];

  int unsigned m_ptr[2];
  int unsigned m_cnt[2];
  int unsigned m_eaddr[2];
  bit          m_err[2];
  bit          m_active[2];
  int unsigned m_max[2] = '{255, 3};
  bit          hold_next[2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference encoder: field values placed by arithmetic weight.
  function automatic logic [31:0] ref_encode(input int unsigned m, input int unsigned rd,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int imm, output bit illegal, output bit oob);
    int unsigned u, f3, f7, w;
    u = imm; illegal = 0; oob = 0; f3 = 0; f7 = 0; w = 32'h13;
    if (m <= 9) begin
      case (m)
        0, 1: f3 = 0;  2: f3 = 7;  3: f3 = 6;  4: f3 = 4;
        5: f3 = 1;  6, 7: f3 = 5;  8: f3 = 2;  default: f3 = 3;
      endcase
      f7 = (m == 1 || m == 7) ? 32 : 0;
      w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 51;
    end else if (m <= 15) begin
      case (m)
        10: f3 = 0;  11: f3 = 7;  12: f3 = 6;  13: f3 = 4;  14: f3 = 2;  default: f3 = 3;
      endcase
      w = ((u & 4095) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 19;
      oob = (imm < -2048) || (imm > 2047);
    end else if (m <= 18) begin
      f3 = (m == 16) ? 1 : 5;
      f7 = (m == 18) ? 32 : 0;
      w = (f7 << 25) | ((u & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 19;
      oob = (imm < 0) || (imm > 31);
    end else if (m == 19) begin
      w = ((u & 4095) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 3;
      oob = (imm < -2048) || (imm > 2047);
    end else if (m == 20) begin
      w = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((u & 31) << 7) | 35;
      oob = (imm < -2048) || (imm > 2047);
    end else if (m == 21) begin
      w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
        | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 99;
      oob = (imm < -4096) || (imm > 4095) || ((u & 1) != 0);
    end else if (m == 22) begin
      w = ((u & 32'hFFFFF) << 12) | (rd << 7) | 55;
      oob = (imm < 0) || (imm > 1048575);
    end else if (m == 23) begin
      w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
        | (((u >> 12) & 255) << 12) | (rd << 7) | 111;
      oob = (imm < -1048576) || (imm > 1048575) || ((u & 1) != 0);
    end else begin
      illegal = 1;
    end
    return w;
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 0) ? if8.in_ready : if2.in_ready;
  endfunction
  function automatic logic get_hold(input int d);
    return (d == 0) ? hold8 : hold2;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? err8 : err2;
  endfunction
  function automatic logic [31:0] get_count(input int d);
    return (d == 0) ? 32'(count8) : 32'(count2);
  endfunction

  task automatic drive(input int d, input int unsigned m, input int unsigned rd, input int unsigned rs1,
                       input int unsigned rs2, input int imm, input bit last, input bit v);
    if (d == 0) begin
      if8.in_mnem = 5'(m); if8.in_rd = 5'(rd); if8.in_rs1 = 5'(rs1); if8.in_rs2 = 5'(rs2);
      if8.in_imm = imm; if8.in_last = last; if8.in_valid = v;
    end else begin
      if2.in_mnem = 5'(m); if2.in_rd = 5'(rd); if2.in_rs1 = 5'(rs1); if2.in_rs2 = 5'(rs2);
      if2.in_imm = imm; if2.in_last = last; if2.in_valid = v;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input int d, input int unsigned m, input int unsigned rd, input int unsigned rs1,
                      input int unsigned rs2, input int imm, input bit last, input bit use_k,
                      input logic [31:0] kword);
    bit ill, oob, bad, ovf;
    logic [31:0] w;
    int unsigned g;
    wr_t  wr;
    end_t en;
    w = ref_encode(m, rd, rs1, rs2, imm, ill, oob);
    if (use_k) w = kword;
    drive(d, m, rd, rs1, rs2, imm, last, 1'b1);
    if (!m_active[d]) begin
      repeat (2) begin
        @(negedge clk);
        check($sformatf("d%0d_no_accept", d), get_ready(d), 1'b0);
      end
    end else begin
      g = 0;
      @(negedge clk);
      while (!get_ready(d) && g < 20) begin @(negedge clk); g++; end
      check($sformatf("d%0d_in_ready", d), get_ready(d), 1'b1);
      bad = ill || (IMM_CHK && oob);
      ovf = (m_ptr[d] == m_max[d]) && !last;
      wr.addr = m_ptr[d]; wr.word = w;
      if (d == 0) q_wr0.push_back(wr); else q_wr1.push_back(wr);
      m_cnt[d]++;
      if ((bad || ovf) && !m_err[d]) begin m_err[d] = 1; m_eaddr[d] = m_ptr[d]; end
      if (m_ptr[d] < m_max[d]) m_ptr[d]++;
      if (last || ovf) begin
        en.cnt = m_cnt[d]; en.err = m_err[d]; en.eaddr = m_eaddr[d];
        if (d == 0) q_end0.push_back(en); else q_end1.push_back(en);
        m_active[d] = 0;
      end
    end
    @(posedge clk); #1;
    drive(d, 0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic start_session(input int d);
    @(negedge clk);
    check($sformatf("d%0d_idle_ready", d), get_ready(d), 1'b0);
    check($sformatf("d%0d_idle_hold", d), get_hold(d), 1'b0);
    if (d == 0) start8 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    if (d == 0) start8 = 1'b0; else start2 = 1'b0;
    m_ptr[d] = 0; m_cnt[d] = 0; m_err[d] = 0; m_active[d] = 1;
    @(negedge clk);
    check($sformatf("d%0d_start_ready", d), get_ready(d), 1'b1);
    check($sformatf("d%0d_start_hold", d), get_hold(d), 1'b1);
    check($sformatf("d%0d_start_err_clear", d), get_err(d), 1'b0);
    check($sformatf("d%0d_start_count_clear", d), get_count(d), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_end(input int d);
    int unsigned g;
    g = 0;
    @(negedge clk);
    while (get_hold(d) && g < 20) begin @(negedge clk); g++; end
    check($sformatf("d%0d_hold_released", d), get_hold(d), 1'b0);
    check($sformatf("d%0d_done_seen", d), (d == 0) ? q_end0.size() : q_end1.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic mon(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic dn, input logic er, input logic [31:0] ea, input logic [31:0] cnt,
                     input logic hold);
    wr_t  w;
    end_t e;
    bit   have;
    if (hold_next[d]) begin
      check($sformatf("d%0d_hold_low_after_done", d), hold, 1'b0);
      hold_next[d] = 0;
    end
    if (we === 1'b1) begin
      have = 0;
      if (d == 0 && q_wr0.size() > 0) begin w = q_wr0.pop_front(); have = 1; end
      if (d == 1 && q_wr1.size() > 0) begin w = q_wr1.pop_front(); have = 1; end
      if (!have) check($sformatf("d%0d_unexpected_write", d), we, 1'b0);
      else begin
        check($sformatf("d%0d_wr_addr", d), addr, w.addr);
        check($sformatf("d%0d_wr_data@%0d", d, w.addr), wdata, w.word);
      end
    end
    if (dn === 1'b1) begin
      have = 0;
      if (d == 0 && q_end0.size() > 0) begin e = q_end0.pop_front(); have = 1; end
      if (d == 1 && q_end1.size() > 0) begin e = q_end1.pop_front(); have = 1; end
      if (!have) check($sformatf("d%0d_unexpected_done", d), dn, 1'b0);
      else begin
        check($sformatf("d%0d_end_count", d), cnt, e.cnt);
        check($sformatf("d%0d_end_err", d), er, e.err);
        if (e.err) check($sformatf("d%0d_end_err_addr", d), ea, e.eaddr);
        check($sformatf("d%0d_hold_at_done", d), hold, 1'b1);
        hold_next[d] = 1;
      end
    end
  endtask

  always @(negedge clk) mon(0, we8, 32'(addr8), wdata8, done8, err8, 32'(eaddr8), 32'(count8), hold8);
  always @(negedge clk) mon(1, we2, 32'(addr2), wdata2, done2, err2, 32'(eaddr2), 32'(count2), hold2);

  task automatic check_reset_values;
    check("rst_ready", if8.in_ready, 1'b0);
    check("rst_we", we8, 1'b0);
    check("rst_addr", addr8, 0);
    check("rst_wdata", wdata8, 0);
    check("rst_hold", hold8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_err", err8, 1'b0);
    check("rst_err_addr", eaddr8, 0);
    check("rst_count", count8, 0);
  endtask

  initial begin : stim
    int unsigned len, d, m;
    int imm_r;
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values();
    check("rst2_ready", if2.in_ready, 1'b0);
    check("rst2_count", count2, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // add x3,x1,x2 as a single-word program
    start_session(0);
    send(0, 0, 3, 1, 2, 0, 1'b1, 1'b1, 32'h002081B3);
    wait_end(0);

    // back-to-back descriptors covering I, U, S, B and J formats
    start_session(0);
    send(0, 10, 5, 0, 0, -1, 1'b0, 1'b1, 32'hFFF00293);
    send(0, 22, 1, 0, 0, 32'h12345, 1'b0, 1'b1, 32'h123450B7);
    send(0, 20, 0, 1, 2, 8, 1'b0, 1'b1, 32'h0020A423);
    send(0, 21, 0, 1, 2, -4, 1'b0, 1'b1, 32'hFE208EE3);
    send(0, 23, 1, 0, 0, 8, 1'b1, 1'b1, 32'h008000EF);
    wait_end(0);

    // illegal mnemonic at address 1
    start_session(0);
    send(0, 10, 1, 0, 0, 5, 1'b0, 1'b0, 32'h0);
    send(0, 27, 4, 5, 6, 0, 1'b1, 1'b1, 32'h00000013);
    wait_end(0);

    // next start clears the sticky error
    start_session(0);
    send(0, 5, 7, 8, 9, 0, 1'b1, 1'b0, 32'h0);
    wait_end(0);

    // addi x0,x0,2048: truncated word, error only with range checking
    start_session(0);
    send(0, 10, 0, 0, 0, 2048, 1'b1, 1'b1, 32'h80000013);
    wait_end(0);

    // 2-bit pointer: five descriptors with no in_last
    start_session(1);
    for (int i = 0; i < 5; i++) send(1, 10, i + 1, 0, 0, i, 1'b0, 1'b0, 32'h0);
    wait_end(1);

    // randomized sessions on both loaders
    for (int s = 0; s < 24; s++) begin
      d = (s % 3 == 2) ? 1 : 0;
      len = $urandom_range(1, (d == 1) ? 6 : 10);
      start_session(d);
      for (int k = 0; k < int'(len); k++) begin
        m = $urandom_range(0, 27);
        imm_r = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 4095)) - 2048;
        send(d, m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm_r,
             (k == int'(len) - 1), 1'b0, 32'h0);
      end
      wait_end(d);
    end

    // reset in the middle of a session
    start_session(0);
    send(0, 0, 1, 2, 3, 0, 1'b0, 1'b0, 32'h0);
    send(0, 26, 1, 2, 3, 0, 1'b0, 1'b0, 32'h0);
    rstn = 1'b0;
    m_active[0] = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_values();
    rstn = 1'b1;
    @(posedge clk); #1;

    // loader usable again after the abort
    start_session(0);
    send(0, 1, 10, 11, 12, 0, 1'b1, 1'b0, 32'h0);
    wait_end(0);

    repeat (3) @(posedge clk);
    check("leftover_wr0", q_wr0.size(), 0);
    check("leftover_wr1", q_wr1.size(), 0);
    check("leftover_end0", q_end0.size(), 0);
    check("leftover_end1", q_end1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
